// File: rtl/bp_pkg.sv
// Shared types for the return-PC predictor update queue.
// bp_update_t is the unit stored in the FIFO and compared by the duplicate filter.
package bp_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_CALL = 2'd1,
    KIND_RET  = 2'd2,
    KIND_RSVD = 2'd3
  } bp_kind_t;

  typedef struct packed {
    bp_kind_t    kind;
    logic [31:0] pc;
    logic [31:0] target;
  } bp_update_t;

  // A call's return address skips the delay slot.
  localparam logic [31:0] RET_OFFSET = 32'd8;

endpackage

// File: rtl/bp_update_queue_if.sv
// Execute-side event handshake plus the predictor update port.
// The slave side is the queue; the master side is the surrounding pipeline.
interface bp_update_queue_if;
  import bp_pkg::*;

  logic        in_valid;
  logic        in_ready;
  bp_kind_t    in_kind;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic        drain_en;
  logic        is_call;
  logic        is_ret;
  logic [31:0] call_pc;
  logic [31:0] ret_pc;
  logic [31:0] jrra_pc;

  modport slave (
    input  in_valid, in_kind, in_pc, in_target, drain_en,
    output in_ready, is_call, is_ret, call_pc, ret_pc, jrra_pc
  );

  modport master (
    output in_valid, in_kind, in_pc, in_target, drain_en,
    input  in_ready, is_call, is_ret, call_pc, ret_pc, jrra_pc
  );
endinterface

// File: rtl/bp_fifo.sv
// Circular buffer of DEPTH update records; the caller guarantees no push when
// full and no pop when empty, so the buffer itself does no overflow checking.
module bp_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  bp_update_t               push_data,
  input  logic                     pop,
  output bp_update_t               pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  bp_update_t    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  assign pop_data = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/bp_update_queue.sv
// Filters call/return events, buffers them, and drains one per cycle into the
// return-PC predictor as registered single-cycle update strobes.
module bp_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  bp_update_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_BITS-1:0]    dup_drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  bp_update_t in_rec;
  bp_update_t last_rec;
  bp_update_t head_rec;
  logic       last_valid;
  logic       accept;
  logic       is_event;
  logic       is_dup;
  logic       push;
  logic       pop;

  assign in_rec = '{kind: bus.in_kind, pc: bus.in_pc, target: bus.in_target};

  // Ready is held low through reset so nothing is consumed before the queue exists.
  assign bus.in_ready = resetn && (count != FULL_CNT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_event     = (bus.in_kind == KIND_CALL) || (bus.in_kind == KIND_RET);
  assign is_dup       = last_valid && (in_rec == last_rec);
  assign push         = accept && is_event && !is_dup;
  assign pop          = (count != '0) && bus.drain_en;

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (in_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .count     (count)
  );

  // Forgetting the last record on drain-to-empty lets a repeat event re-train.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_valid <= 1'b0;
      last_rec   <= '0;
    end else if (push) begin
      last_valid <= 1'b1;
      last_rec   <= in_rec;
    end else if (pop && count == ONE_CNT) begin
      last_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dup_drop_cnt <= '0;
    end else if (accept && is_event && is_dup && dup_drop_cnt != '1) begin
      dup_drop_cnt <= dup_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.is_call <= 1'b0;
      bus.is_ret  <= 1'b0;
      bus.call_pc <= '0;
      bus.ret_pc  <= '0;
      bus.jrra_pc <= '0;
    end else begin
      bus.is_call <= 1'b0;
      bus.is_ret  <= 1'b0;
      if (pop) begin
        if (head_rec.kind == KIND_CALL) begin
          bus.is_call <= 1'b1;
          bus.call_pc <= head_rec.pc;
          bus.ret_pc  <= head_rec.pc + RET_OFFSET;
          bus.jrra_pc <= '0;
        end else begin
          bus.is_ret  <= 1'b1;
          bus.call_pc <= '0;
          bus.ret_pc  <= head_rec.target;
          bus.jrra_pc <= head_rec.pc;
        end
      end
    end
  end

endmodule
